// File: rtl/sram_rw_port_ctrl.sv
// Requester-side controller for a single-port RW0 SRAM macro: valid/ready request stream
// in, SRAM strobes out, one-cycle read data captured into a credit-bounded response FIFO.

module sram_rw_rsp_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 256,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CNT_W-1:0]  cnt_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [PTR_W-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push_i) wptr_d = ptr_inc(wptr_q);
    if (pop_i)  rptr_d = ptr_inc(rptr_q);
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload needs no reset: it is only observed when the count says it is live.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= data_i;
  end

  assign head_o = mem_q[rptr_q];
  assign cnt_o  = cnt_q;
endmodule

module sram_rw_port_ctrl #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 256,
  parameter int MASK_W    = 32,
  parameter int RSP_DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [MASK_W-1:0] req_be_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              sram_en_o,
  output logic              sram_wmode_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [MASK_W-1:0] sram_wmask_o,
  output logic [DATA_W-1:0] sram_wdata_o,
  input  logic [DATA_W-1:0] sram_rdata_i,
  output logic              idle_o
);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic              inflight_q, inflight_d;
  logic              fire;
  logic              push, pop;
  logic [DATA_W-1:0] head;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W:0]    credit;
  logic              empty;

  // A read only issues if its response already has a guaranteed FIFO slot.
  assign credit      = {1'b0, cnt} + (CNT_W + 1)'(inflight_q);
  assign req_ready_o = rst_ni && (credit < (CNT_W + 1)'(RSP_DEPTH));
  assign fire        = req_valid_i && req_ready_o;

  assign sram_en_o    = fire;
  assign sram_wmode_o = req_we_i;
  assign sram_addr_o  = req_addr_i;
  assign sram_wdata_o = req_wdata_i;
  assign sram_wmask_o = (fire && req_we_i) ? req_be_i : '0;

  assign inflight_d = fire && !req_we_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) inflight_q <= 1'b0;
    else         inflight_q <= inflight_d;
  end

  assign empty = (cnt == '0);

  // Fresh SRAM data bypasses an empty FIFO; otherwise it queues behind older responses.
  always_comb begin
    push        = 1'b0;
    pop         = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    if (inflight_q) begin
      rsp_valid_o = 1'b1;
      if (empty) begin
        rsp_rdata_o = sram_rdata_i;
        push        = !rsp_ready_i;
      end else begin
        rsp_rdata_o = head;
        push        = 1'b1;
        pop         = rsp_ready_i;
      end
    end else if (!empty) begin
      rsp_valid_o = 1'b1;
      rsp_rdata_o = head;
      pop         = rsp_ready_i;
    end
  end

  sram_rw_rsp_fifo #(
    .DEPTH  (RSP_DEPTH),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_rsp_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .data_i (sram_rdata_i),
    .pop_i  (pop),
    .head_o (head),
    .cnt_o  (cnt)
  );

  assign idle_o = !inflight_q && empty;
endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Scoreboard bench for sram_rw_port_ctrl: directed vectors drive requests, a forked
// monitor pops expected read data whenever a response handshake occurs.

module tb_sram_rw_port_ctrl;
  localparam int AW = 9;
  localparam int DW = 256;
  localparam int MW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_valid_i, req_ready_o, req_we_i;
  logic [AW-1:0] req_addr_i;
  logic [MW-1:0] req_be_i;
  logic [DW-1:0] req_wdata_i;
  logic          rsp_valid_o, rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          sram_en_o, sram_wmode_o;
  logic [AW-1:0] sram_addr_o;
  logic [MW-1:0] sram_wmask_o;
  logic [DW-1:0] sram_wdata_o, sram_rdata_i;
  logic          idle_o;

  always #5 clk_i = ~clk_i;

  sram_rw_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .RSP_DEPTH(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_be_i(req_be_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .sram_en_o(sram_en_o), .sram_wmode_o(sram_wmode_o), .sram_addr_o(sram_addr_o),
    .sram_wmask_o(sram_wmask_o), .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i),
    .idle_o(idle_o)
  );

  // RW0 macro model: rdata is only meaningful the cycle after a read, garbage otherwise.
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_q, garbage_q;
  logic          rd_v_q;
  initial begin
    for (int i = 0; i < (1 << AW); i++) sram_mem[i] = '0;
    rd_q = '0; rd_v_q = 1'b0; garbage_q = '0;
  end
  always @(posedge clk_i) begin
    rd_v_q    <= sram_en_o && !sram_wmode_o;
    garbage_q <= {8{$urandom}};
    if (sram_en_o) begin
      if (sram_wmode_o) begin
        for (int g = 0; g < MW; g++)
          if (sram_wmask_o[g]) sram_mem[sram_addr_o][g*8 +: 8] <= sram_wdata_o[g*8 +: 8];
      end else begin
        rd_q <= sram_mem[sram_addr_o];
      end
    end
  end
  assign sram_rdata_i = rd_v_q ? rd_q : garbage_q;

  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_q [$];
  int            checks = 0;
  int            errors = 0;
  int            rdy_mode = 1;
  int            max_run = 0;
  int            stall_cnt = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk_i);
    #1;
  endtask

  // Called 1 time unit after a posedge; returns 1 time unit after the accepting edge.
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [MW-1:0] be,
                       input logic [DW-1:0] d, input logic expect_rsp);
    int n = 0;
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = a; req_be_i = be; req_wdata_i = d;
    @(negedge clk_i);
    while (!req_ready_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n > 0) stall_cnt++;
    if (!req_ready_o) begin
      chk("issue_timeout", {255'd0, req_ready_o}, 1);
    end else begin
      chk("fire_en", {255'd0, sram_en_o}, 1);
      chk("fire_wmode", {255'd0, sram_wmode_o}, {255'd0, we});
      chk("fire_addr", {{(DW-AW){1'b0}}, sram_addr_o}, {{(DW-AW){1'b0}}, a});
      chk("fire_wmask", {{(DW-MW){1'b0}}, sram_wmask_o}, we ? {{(DW-MW){1'b0}}, be} : '0);
      chk("fire_wdata", sram_wdata_o, d);
      if (we) begin
        for (int g = 0; g < MW; g++)
          if (be[g]) ref_mem[a][g*8 +: 8] = d[g*8 +: 8];
      end else if (expect_rsp) begin
        exp_q.push_back(ref_mem[a]);
      end
    end
    sync();
    req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain_empty", DW'(exp_q.size()), 0);
    @(negedge clk_i);
  endtask

  localparam logic [DW-1:0] D5  = {8{32'hDEADBEEF}};
  localparam logic [DW-1:0] D20 = {8{32'h20202020}};
  localparam logic [DW-1:0] D21 = {8{32'h21212121}};

  initial begin
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = '0;
    rst_ni = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0;
    req_be_i = '0; req_wdata_i = '0; rsp_ready_i = 1'b1;

    fork
      forever begin
        @(posedge clk_i);
        #1;
        rsp_ready_i = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
      end
      begin : monitor
        logic          prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        int            run = 0;
        forever begin
          @(negedge clk_i);
          if (!req_valid_i || !rst_ni) chk("no_req_no_en", {255'd0, sram_en_o}, 0);
          if (!(sram_en_o && sram_wmode_o)) chk("idle_wmask", {{(DW-MW){1'b0}}, sram_wmask_o}, 0);
          if (prev_stall && rst_ni) begin
            chk("stall_valid", {255'd0, rsp_valid_o}, 1);
            chk("stall_data", rsp_rdata_o, prev_data);
          end
          if (rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) chk("unexpected_rsp", {255'd0, rsp_valid_o}, 0);
            else chk("rsp_data", rsp_rdata_o, exp_q.pop_front());
            run++;
            if (run > max_run) max_run = run;
          end else begin
            run = 0;
          end
          prev_stall = rst_ni && rsp_valid_o && !rsp_ready_i;
          prev_data  = rsp_rdata_o;
        end
      end
    join_none

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_ready", {255'd0, req_ready_o}, 0);
    chk("rst_rsp_valid", {255'd0, rsp_valid_o}, 0);
    chk("rst_rdata", rsp_rdata_o, 0);
    chk("rst_idle", {255'd0, idle_o}, 1);
    sync();
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_rst_ready", {255'd0, req_ready_o}, 1);
    sync();

    // Full write then read-after-write, one-cycle latency
    issue(1'b1, 9'h005, '1, D5, 1'b1);
    issue(1'b0, 9'h005, '0, '0, 1'b1);
    @(negedge clk_i);
    chk("raw_latency_valid", {255'd0, rsp_valid_o}, 1);
    chk("raw_data", rsp_rdata_o, D5);
    sync();

    // Single-granule write over a zero word
    issue(1'b1, 9'h010, 32'h0000_0001, '1, 1'b1);
    issue(1'b0, 9'h010, '0, '0, 1'b1);
    @(negedge clk_i);
    chk("partial_data", rsp_rdata_o, 256'hFF);
    sync();

    // Backpressure: two reads fill the credit, a third is refused
    issue(1'b1, 9'h020, '1, D20, 1'b1);
    issue(1'b1, 9'h021, '1, D21, 1'b1);
    rdy_mode = 0;
    sync();
    issue(1'b0, 9'h020, '0, '0, 1'b1);
    issue(1'b0, 9'h021, '0, '0, 1'b1);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 9'h022;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("full_ready", {255'd0, req_ready_o}, 0);
      chk("full_en", {255'd0, sram_en_o}, 0);
    end
    chk("stalled_head", rsp_rdata_o, D20);
    sync();
    req_valid_i = 1'b0;
    rdy_mode = 1;
    drain();
    sync();

    // 16 back-to-back reads at full throughput
    for (int i = 0; i < 16; i++)
      issue(1'b1, AW'(9'h040 + i), '1, {8{32'(i) * 32'h0101_0101}}, 1'b1);
    stall_cnt = 0;
    for (int i = 0; i < 16; i++) issue(1'b0, AW'(9'h040 + i), '0, '0, 1'b1);
    drain();
    chk("b2b_no_stall", DW'(stall_cnt), 0);
    chk("b2b_run", DW'(max_run >= 16), 1);
    sync();

    // Mixed stream under random response backpressure
    rdy_mode = 2;
    sync();
    for (int i = 0; i < 40; i++)
      issue(1'($urandom_range(0, 1)), AW'(9'h080 + $urandom_range(0, 7)), $urandom,
            {8{$urandom}}, 1'b1);
    rdy_mode = 1;
    drain();
    chk("mixed_idle", {255'd0, idle_o}, 1);
    sync();

    // Reset while a read is in flight
    issue(1'b0, 9'h005, '0, '0, 1'b0);
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_valid", {255'd0, rsp_valid_o}, 0);
    chk("mid_rst_rdata", rsp_rdata_o, 0);
    chk("mid_rst_idle", {255'd0, idle_o}, 1);
    chk("mid_rst_ready", {255'd0, req_ready_o}, 0);
    sync();
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("post_rst_idle", {255'd0, idle_o}, 1);
    chk("post_rst_no_rsp", {255'd0, rsp_valid_o}, 0);
    sync();
    issue(1'b0, 9'h005, '0, '0, 1'b1);
    @(negedge clk_i);
    chk("post_rst_read", rsp_rdata_o, D5);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
